fpd_seq: RTL and testbench



---
 rtl/fp_pkg.sv | 47 ++++
 rtl/fpd_seq_if.sv | 34 +++
 rtl/fpd_norm_round.sv | 75 +++++++
 rtl/fpd_seq.sv | 158 +++++++++++++++
 tb/tb_fpd_seq.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the arithmetic datapath (fpd_seq, fpm).
//
// Contents:
//   MANT_W / EXP_W / BIAS  single-precision field widths and exponent bias
//   SIG_W                  significand width including the hidden bit
//   QW                     quotient bits produced by the divider
//   CNT_W                  width of the divider iteration counter
//   fpd_state_e            divider FSM states
//   fp_sign/fp_exp/fp_mant field extract helpers
//
// Build option: FPD_ROUND_EN adds one guard quotient bit (QW = 26) for
// round-to-nearest-even; without it the divider truncates (QW = 25).
package fp_pkg;

    localparam int MANT_W = 23;
    localparam int EXP_W  = 8;
    localparam int BIAS   = 127;
    localparam int WORD_W = 1 + EXP_W + MANT_W;
    localparam int SIG_W  = MANT_W + 1;

`ifdef FPD_ROUND_EN
    localparam int QW = MANT_W + 3;
`else
    localparam int QW = MANT_W + 2;
`endif

    localparam int CNT_W = $clog2(QW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2
    } fpd_state_e;

    function automatic logic fp_sign(input logic [WORD_W-1:0] w);
        return w[WORD_W-1];
    endfunction

    function automatic logic [EXP_W-1:0] fp_exp(input logic [WORD_W-1:0] w);
        return w[MANT_W+EXP_W-1:MANT_W];
    endfunction

    function automatic logic [MANT_W-1:0] fp_mant(input logic [WORD_W-1:0] w);
        return w[MANT_W-1:0];
    endfunction

endpackage

// File: rtl/fpd_seq_if.sv
// Request/response bundle of the iterative divider.
//
// Signals:
//   start                 request, taken only while the divider is idle
//   in1, additional1      dividend word and its hidden-bit / valid flag
//   in2, additional2      divisor word and its hidden-bit / valid flag
//   busy                  divider iterating or normalising
//   done                  one-cycle pulse, out/additionalout valid
//   out, additionalout    quotient word and combined flag, held until next done
// Modports: master drives requests, slave (the divider) drives responses.
interface fpd_seq_if;
    import fp_pkg::*;

    logic              start;
    logic [WORD_W-1:0] in1;
    logic              additional1;
    logic [WORD_W-1:0] in2;
    logic              additional2;
    logic              busy;
    logic              done;
    logic [WORD_W-1:0] out;
    logic              additionalout;

    modport master (
        output start, in1, additional1, in2, additional2,
        input  busy, done, out, additionalout
    );

    modport slave (
        input  start, in1, additional1, in2, additional2,
        output busy, done, out, additionalout
    );

endinterface

// File: rtl/fpd_norm_round.sv
// Combinational normalise / round / pack stage of the divider.
//
// Ports:
//   quo_i     raw quotient Q = floor(A * 2^(QW-1) / B), QW bits
//   rem_nz_i  final partial remainder is non-zero (sticky source)
//   exp_i     biased exponent before normalisation, EXP_W bits
//   sign_i    result sign
//   res_o     packed {sign, exp, mantissa} result word
//
// Build option: FPD_ROUND_EN selects round-to-nearest-even using the guard
// bit and a sticky of all lower information; otherwise the mantissa is
// truncated and rem_nz_i carries no information.
module fpd_norm_round
    import fp_pkg::*;
(
    input  logic [QW-1:0]     quo_i,
    input  logic              rem_nz_i,
    input  logic [EXP_W-1:0]  exp_i,
    input  logic              sign_i,
    output logic [WORD_W-1:0] res_o
);

    logic [MANT_W-1:0] mant_n;
    logic [EXP_W-1:0]  exp_n;
    logic [MANT_W-1:0] mant_f;
    logic [EXP_W-1:0]  exp_f;

`ifdef FPD_ROUND_EN
    logic              guard;
    logic              sticky;
    logic              round_up;
    logic [MANT_W:0]   mant_inc;

    always_comb begin
        // Q lies in [2^(QW-2), 2^QW): the leading one is at one of the top two bits.
        if (quo_i[QW-1]) begin
            mant_n = quo_i[QW-2 -: MANT_W];
            exp_n  = exp_i;
            guard  = quo_i[QW-2-MANT_W];
            sticky = quo_i[QW-3-MANT_W] | rem_nz_i;
        end else begin
            mant_n = quo_i[QW-3 -: MANT_W];
            exp_n  = exp_i - EXP_W'(1);
            guard  = quo_i[QW-3-MANT_W];
            sticky = rem_nz_i;
        end

        round_up = guard & (sticky | mant_n[0]);
        mant_inc = {1'b0, mant_n} + {{MANT_W{1'b0}}, round_up};

        // A carry out leaves the low bits all zero; bump the exponent.
        mant_f = mant_inc[MANT_W-1:0];
        exp_f  = exp_n + {{(EXP_W-1){1'b0}}, mant_inc[MANT_W]};
    end
`else
    logic unused_rem_nz;

    assign unused_rem_nz = rem_nz_i;

    always_comb begin
        if (quo_i[QW-1]) begin
            mant_n = quo_i[QW-2 -: MANT_W];
            exp_n  = exp_i;
        end else begin
            mant_n = quo_i[QW-3 -: MANT_W];
            exp_n  = exp_i - EXP_W'(1);
        end
        mant_f = mant_n;
        exp_f  = exp_n;
    end
`endif

    assign res_o = {sign_i, exp_f, mant_f};

endmodule

// File: rtl/fpd_seq.sv
// Iterative single-precision floating-point divider (restoring, one quotient
// bit per clock) with a start/busy/done handshake.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset; aborts any operation silently
//   bus_if  fpd_seq_if.slave: start, in1/additional1, in2/additional2 in;
//           busy, done, out, additionalout out
//
// Build option: FPD_ROUND_EN (round-to-nearest-even, one extra iteration).
//
// FSM states:
//   state | meaning
//   IDLE  | waiting for start; operands latched on the accepting edge
//   DIV   | one restoring step per edge, QW steps in total
//   NORM  | normalise/round/pack, register result, pulse done
module fpd_seq
    import fp_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    fpd_seq_if.slave bus_if
);

    fpd_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SIG_W:0]    rem_q, rem_d;
    logic [SIG_W-1:0]  dvs_q, dvs_d;
    logic [QW-1:0]     quo_q, quo_d;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic              sign_q, sign_d;
    logic              add_q, add_d;
    logic [WORD_W-1:0] out_q, out_d;
    logic              addout_q, addout_d;
    logic              done_q, done_d;

    logic              accept;
    logic              last_step;
    logic [SIG_W+1:0]  trial;
    logic              trial_ok;
    logic [SIG_W:0]    rem_keep;
    logic              rem_nz;
    logic [WORD_W-1:0] norm_res;

    assign accept    = (state_q == IDLE) && bus_if.start;
    assign last_step = (cnt_q == '0);
    assign rem_nz    = |rem_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus_if.start) state_d = DIV;
            DIV:     if (last_step) state_d = NORM;
            NORM:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus_if.busy          = (state_q == DIV) || (state_q == NORM);
        bus_if.done          = done_q;
        bus_if.out           = out_q;
        bus_if.additionalout = addout_q;
    end

    // Iteration datapath
    always_comb begin
        // rem < 2B always holds, so the trial needs one bit above rem plus a sign bit.
        trial    = {1'b0, rem_q} - {2'b00, dvs_q};
        trial_ok = ~trial[SIG_W+1];
        rem_keep = trial_ok ? trial[SIG_W:0] : rem_q;

        cnt_d    = cnt_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        quo_d    = quo_q;
        exp_d    = exp_q;
        sign_d   = sign_q;
        add_d    = add_q;
        out_d    = out_q;
        addout_d = addout_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    rem_d  = {1'b0, bus_if.additional1, fp_mant(bus_if.in1)};
                    dvs_d  = {bus_if.additional2, fp_mant(bus_if.in2)};
                    quo_d  = '0;
                    cnt_d  = CNT_W'(QW - 1);
                    // Modulo-2^EXP_W exponent; no range handling by design.
                    exp_d  = fp_exp(bus_if.in1) - fp_exp(bus_if.in2) + EXP_W'(BIAS);
                    sign_d = fp_sign(bus_if.in1) ^ fp_sign(bus_if.in2);
                    add_d  = bus_if.additional1 & bus_if.additional2;
                end
            end
            DIV: begin
                quo_d = {quo_q[QW-2:0], trial_ok};
                rem_d = rem_keep << 1;
                if (!last_step) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            NORM: begin
                out_d    = add_q ? norm_res : '0;
                addout_d = add_q;
                done_d   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            quo_q    <= '0;
            exp_q    <= '0;
            sign_q   <= 1'b0;
            add_q    <= 1'b0;
            out_q    <= '0;
            addout_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            quo_q    <= quo_d;
            exp_q    <= exp_d;
            sign_q   <= sign_d;
            add_q    <= add_d;
            out_q    <= out_d;
            addout_q <= addout_d;
            done_q   <= done_d;
        end
    end

    fpd_norm_round u_norm_round (
        .quo_i    (quo_q),
        .rem_nz_i (rem_nz),
        .exp_i    (exp_q),
        .sign_i   (sign_q),
        .res_o    (norm_res)
    );

endmodule

// File: tb/tb_fpd_seq.sv
// Self-checking bench for fpd_seq: directed operand vectors with literal
// expectations, plus a per-cycle comparison against an arithmetic model of
// the divider's timing and result.
module tb_fpd_seq;

`ifdef FPD_ROUND_EN
    localparam int TQW = 26;
    localparam logic [31:0] ONE_THIRD = 32'h3EAAAAAB;
`else
    localparam int TQW = 25;
    localparam logic [31:0] ONE_THIRD = 32'h3EAAAAAA;
`endif
    // Edges from the accepting edge to the edge that raises done.
    localparam int LAT = TQW + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    fpd_seq_if bus_if ();

    fpd_seq dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (bus_if)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    endtask

    // Exact quotient by integer arithmetic, then IEEE-style field packing.
    function automatic logic [31:0] model_div(input logic [31:0] x, input logic ax,
                                              input logic [31:0] y, input logic ay);
        longint unsigned a, b, num, q, r, mant;
        int e, lead, extra;
        if (!(ax && ay)) return 32'h0;
        a    = 64'({ax, x[22:0]});
        b    = 64'({ay, y[22:0]});
        num  = a << (TQW - 1);
        q    = num / b;
        r    = num % b;
        e    = int'(x[30:23]) - int'(y[30:23]) + 127;
        if (q >= (64'd1 << (TQW - 1))) lead = TQW - 1;
        else begin
            lead = TQW - 2;
            e    = e - 1;
        end
        extra = lead - 23;
        mant  = (q >> extra) & 64'h7FFFFF;
`ifdef FPD_ROUND_EN
        begin
            longint unsigned frac, half;
            frac = q & ((64'd1 << extra) - 1);
            half = 64'd1 << (extra - 1);
            if (frac > half || (frac == half && (r != 0 || mant[0]))) begin
                mant = mant + 1;
                if (mant == 64'h800000) begin
                    mant = 0;
                    e    = e + 1;
                end
            end
        end
`else
        if (r == 64'hFFFF_FFFF_FFFF_FFFF) mant = 0;
`endif
        return {x[31] ^ y[31], e[7:0], mant[22:0]};
    endfunction

    // Timing/result model, advanced on each clock edge.
    bit          m_active, m_done, m_add, m_pend_add;
    int          m_k;
    logic [31:0] m_out, m_pend;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            m_k      = 0;
            m_out    = 32'h0;
            m_add    = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_active) begin
                m_k++;
                if (m_k == LAT) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                    m_out    = m_pend;
                    m_add    = m_pend_add;
                end
            end else if (bus_if.start) begin
                m_active   = 1'b1;
                m_k        = 0;
                m_pend     = model_div(bus_if.in1, bus_if.additional1, bus_if.in2, bus_if.additional2);
                m_pend_add = bus_if.additional1 & bus_if.additional2;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_busy", {31'b0, bus_if.busy}, {31'b0, m_active});
            check("cyc_done", {31'b0, bus_if.done}, {31'b0, m_done});
            check("cyc_out", bus_if.out, m_out);
            check("cyc_addout", {31'b0, bus_if.additionalout}, {31'b0, m_add});
        end
    end

    task automatic wait_done(input string name, output int k, output int nbusy);
        bit seen;
        seen  = 1'b0;
        k     = 0;
        nbusy = 0;
        while (!seen && k < 4 * LAT) begin
            @(negedge clk);
            if (bus_if.done) seen = 1'b1;
            else begin
                if (bus_if.busy) nbusy++;
                k++;
            end
        end
        check({name, "_done_seen"}, {31'b0, seen}, 32'd1);
    endtask

    task automatic count_done(input int ncyc, output int nd);
        nd = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (bus_if.done) nd++;
        end
    endtask

    // Issues one request, scrambles the operands after the accepting edge,
    // and returns at the falling edge of the done cycle.
    task automatic run_op(input string name, input logic [31:0] x, input logic ax,
                          input logic [31:0] y, input logic ay,
                          input logic [31:0] req_out, input logic req_add);
        int k, nbusy;
        bus_if.in1         = x;
        bus_if.additional1 = ax;
        bus_if.in2         = y;
        bus_if.additional2 = ay;
        bus_if.start       = 1'b1;
        @(posedge clk);
        #1;
        bus_if.start       = 1'b0;
        bus_if.in1         = ~x;
        bus_if.in2         = ~y;
        bus_if.additional1 = ~ax;
        bus_if.additional2 = ~ay;
        wait_done(name, k, nbusy);
        check({name, "_latency"}, 32'(k), 32'(LAT));
        check({name, "_busy_cycles"}, 32'(nbusy), 32'(LAT));
        check({name, "_out"}, bus_if.out, req_out);
        check({name, "_addout"}, {31'b0, bus_if.additionalout}, {31'b0, req_add});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, nbusy, nd;
        bus_if.start       = 1'b0;
        bus_if.in1         = 32'h0;
        bus_if.in2         = 32'h0;
        bus_if.additional1 = 1'b0;
        bus_if.additional2 = 1'b0;

        #3 rst_n = 1'b0;
        #1;
        check("reset_busy", {31'b0, bus_if.busy}, 32'd0);
        check("reset_done", {31'b0, bus_if.done}, 32'd0);
        check("reset_out", bus_if.out, 32'h0);
        check("reset_addout", {31'b0, bus_if.additionalout}, 32'd0);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Pin the model against hand-computed values.
        check("model_6_2", model_div(32'h40C00000, 1, 32'h40000000, 1), 32'h40400000);
        check("model_1_3", model_div(32'h3F800000, 1, 32'h40400000, 1), ONE_THIRD);
        check("model_m15_05", model_div(32'hBFC00000, 1, 32'h3F000000, 1), 32'hC0400000);

        run_op("div6_2", 32'h40C00000, 1, 32'h40000000, 1, 32'h40400000, 1);
        repeat (3) @(negedge clk);
        run_op("div1_3", 32'h3F800000, 1, 32'h40400000, 1, ONE_THIRD, 1);
        repeat (2) @(negedge clk);
        run_op("divm15_05", 32'hBFC00000, 1, 32'h3F000000, 1, 32'hC0400000, 1);
        // Back-to-back: start raised in the done cycle.
        run_op("b2b_15_15", 32'h3FC00000, 1, 32'h3FC00000, 1, 32'h3F800000, 1);
        repeat (2) @(negedge clk);
        run_op("noadd1", 32'h40C00000, 0, 32'h40000000, 1, 32'h00000000, 0);
        repeat (2) @(negedge clk);

        // Extra vectors checked against the model.
        run_op("near_one", 32'h3F800001, 1, 32'h3F7FFFFF, 1,
               model_div(32'h3F800001, 1, 32'h3F7FFFFF, 1), 1);
        run_op("exp_wrap", 32'h7F000000, 1, 32'h00800000, 1,
               model_div(32'h7F000000, 1, 32'h00800000, 1), 1);
        run_op("max_mant", 32'h3FFFFFFF, 1, 32'h3F800001, 1,
               model_div(32'h3FFFFFFF, 1, 32'h3F800001, 1), 1);
        run_op("neg_div", 32'h41200000, 1, 32'hC0E00000, 1,
               model_div(32'h41200000, 1, 32'hC0E00000, 1), 1);
        repeat (2) @(negedge clk);

        // Start while busy is ignored.
        bus_if.in1 = 32'h40C00000; bus_if.additional1 = 1'b1;
        bus_if.in2 = 32'h40000000; bus_if.additional2 = 1'b1;
        bus_if.start = 1'b1;
        @(posedge clk);
        #1 bus_if.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus_if.in1 = 32'h3F800000; bus_if.in2 = 32'h40400000;
        bus_if.start = 1'b1;
        @(posedge clk);
        #1 bus_if.start = 1'b0;
        wait_done("ignored_start", k, nbusy);
        check("ignored_start_out", bus_if.out, 32'h40400000);
        count_done(2 * LAT, nd);
        check("ignored_start_no_second_done", 32'(nd), 32'd0);

        // Asynchronous reset mid-operation.
        bus_if.in1 = 32'h3F800000; bus_if.in2 = 32'h40400000;
        bus_if.start = 1'b1;
        @(posedge clk);
        #1 bus_if.start = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", {31'b0, bus_if.busy}, 32'd0);
        check("abort_done", {31'b0, bus_if.done}, 32'd0);
        check("abort_out", bus_if.out, 32'h0);
        check("abort_addout", {31'b0, bus_if.additionalout}, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        count_done(LAT + 5, nd);
        check("abort_no_done", 32'(nd), 32'd0);
        run_op("after_reset", 32'h40C00000, 1, 32'h40000000, 1, 32'h40400000, 1);

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
